dfc_result_collector: RTL

//  Downstream stage of the data-folding calculator (DFC). Captures each

---
 rtl/dfc_result_collector_if.sv | 29 ++
 rtl/dfc_result_collector.sv | 116 +++++++++++
 2 files changed

// File: rtl/dfc_result_collector_if.sv
// Burst input and summary output bundle of the DFC result collector.
// The slave side is the collector; the master side feeds words and drains summaries.
interface dfc_result_collector_if #(
  parameter int W         = 9,
  parameter int BURST_LEN = 4
);
  localparam int SUM_W = W + $clog2(BURST_LEN);

  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W-1:0] res_sum;
  logic [W-1:0]     res_max;
  logic [W-1:0]     res_min;
  logic             full;
  logic             err_abort;
  logic             err_ovf;

  modport master (
    output in_data, in_valid, res_ready,
    input  res_valid, res_sum, res_max, res_min, full, err_abort, err_ovf
  );

  modport slave (
    input  in_data, in_valid, res_ready,
    output res_valid, res_sum, res_max, res_min, full, err_abort, err_ovf
  );
endinterface

// File: rtl/dfc_result_collector.sv
// Reduces each BURST_LEN-word DFC result burst to sum/max/min and queues the
// summaries in a small circular FIFO behind a valid/ready port.
module dfc_result_collector #(
  parameter int W         = 9,
  parameter int BURST_LEN = 4,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dfc_result_collector_if.slave bus
);
  localparam int SUM_W = W + $clog2(BURST_LEN);
  localparam int CW    = $clog2(BURST_LEN + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW    = $clog2(DEPTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [W-1:0]     max;
    logic [W-1:0]     min;
  } summ_t;

  logic [0:0]    state;
  logic [CW-1:0] cnt, cnt_nxt;
  summ_t         acc, nxt, head;
  summ_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          push, pop, is_full, wr_en, abort_q, ovf_q;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Fold the current word into the running summary; IDLE starts a fresh one.
  always_comb begin
    nxt     = acc;
    cnt_nxt = cnt;
    if (state == IDLE) begin
      nxt.sum = SUM_W'(bus.in_data);
      nxt.max = bus.in_data;
      nxt.min = bus.in_data;
      cnt_nxt = CW'(1);
    end else begin
      nxt.sum = acc.sum + SUM_W'(bus.in_data);
      if (bus.in_data > acc.max) nxt.max = bus.in_data;
      if (bus.in_data < acc.min) nxt.min = bus.in_data;
      cnt_nxt = cnt + CW'(1);
    end
  end

  assign push    = bus.in_valid && (cnt_nxt == CW'(BURST_LEN));
  assign pop     = (count != '0) && bus.res_ready;
  assign is_full = (count == NW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign wr_en   = push && (!is_full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      abort_q <= (state == ACC) && !bus.in_valid;
      ovf_q   <= push && is_full && !pop;
      if (bus.in_valid) begin
        acc <= nxt;
        if (push) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= ACC;
          cnt   <= cnt_nxt;
        end
      end else if (state == ACC) begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= inc(wr_ptr);
      if (pop)   rd_ptr <= inc(rd_ptr);
      case ({wr_en, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Summary outputs read zero whenever nothing is queued, including after reset.
  assign head          = mem[rd_ptr];
  assign bus.res_valid = (count != '0);
  assign bus.res_sum   = bus.res_valid ? head.sum : '0;
  assign bus.res_max   = bus.res_valid ? head.max : '0;
  assign bus.res_min   = bus.res_valid ? head.min : '0;
  assign bus.full      = is_full;
  assign bus.err_abort = abort_q;
  assign bus.err_ovf   = ovf_q;
endmodule
